// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : cache_controller
// Purpose  : 2-way set-associative read cache in front of an SRAM controller.
//            Same-cycle read hits, two-word block fill on read miss,
//            write-through / no-write-allocate stores.
//            Optional hit/miss counters when CACHE_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module cache_controller #(
    parameter int BASE_ADDR = 1024,
    parameter int SET_BITS  = 6,
    parameter int TAG_BITS  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdEnIn,
    input  logic        wrEnIn,
    input  logic [31:0] addressIn,
    input  logic [31:0] writeDataIn,
    output logic [31:0] readDataOut,
    output logic        readyOut,
    output logic        sramRdEnOut,
    output logic        sramWrEnOut,
    output logic [31:0] sramAddressOut,
    output logic [31:0] sramWriteDataOut,
    input  logic [31:0] sramReadDataIn,
    input  logic        sramReadyIn
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0] hitCountOut,
    output logic [15:0] missCountOut
`endif
);

    localparam int          c_NUM_SETS = 1 << SET_BITS;
    localparam logic [31:0] c_BASE     = 32'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILL_LO = 2'd1,
        S_FILL_HI = 2'd2,
        S_WRITE   = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_wr_done;
    logic [31:0]         r_fill_buf;

    logic                r_valid [2][c_NUM_SETS];
    logic [TAG_BITS-1:0] r_tag   [2][c_NUM_SETS];
    logic [31:0]         r_data0 [2][c_NUM_SETS];
    logic [31:0]         r_data1 [2][c_NUM_SETS];
    logic                r_lru   [c_NUM_SETS];

    logic [31:0]         w_rel;
    logic [29:0]         w_word;
    logic                w_offset;
    logic [SET_BITS-1:0] w_index;
    logic [TAG_BITS-1:0] w_tag;
    logic [31:0]         w_blk;
    logic                w_unused;
    logic                w_hit0;
    logic                w_hit1;
    logic                w_hit;
    logic                w_hit_way;
    logic [31:0]         w_hit_word;
    logic                w_victim;
    logic                w_idle_live;
    logic                w_rd_hit;
    logic                w_miss_start;
    logic                w_fill_done;
    logic                w_write_done;

    assign w_rel    = addressIn - c_BASE;
    assign w_word   = w_rel[31:2];
    assign w_offset = w_word[0];
    assign w_index  = w_word[SET_BITS:1];
    assign w_tag    = w_word[SET_BITS+TAG_BITS:SET_BITS+1];
    assign w_blk    = c_BASE + {w_rel[31:3], 3'b000};
    assign w_unused = ^w_rel[1:0];

    assign w_hit0     = r_valid[0][w_index] && (r_tag[0][w_index] == w_tag);
    assign w_hit1     = r_valid[1][w_index] && (r_tag[1][w_index] == w_tag);
    assign w_hit      = w_hit0 | w_hit1;
    assign w_hit_way  = ~w_hit0;
    assign w_hit_word = w_offset ? r_data1[w_hit_way][w_index] : r_data0[w_hit_way][w_index];
    assign w_victim   = r_lru[w_index];

    // The cycle right after a write completes is held not-ready so the
    // still-present write request is not decoded a second time.
    assign w_idle_live  = (r_state == S_IDLE) && !r_wr_done;
    assign w_rd_hit     = w_idle_live && rdEnIn && !wrEnIn && w_hit;
    assign w_miss_start = w_idle_live && rdEnIn && !wrEnIn && !w_hit;
    assign w_fill_done  = (r_state == S_FILL_HI) && sramReadyIn;
    assign w_write_done = (r_state == S_WRITE) && sramReadyIn;

    assign readyOut    = (w_idle_live && !wrEnIn && !w_miss_start) || w_write_done;
    assign readDataOut = w_rd_hit ? w_hit_word : 32'h0;

    always_comb begin
        sramRdEnOut      = 1'b0;
        sramWrEnOut      = 1'b0;
        sramAddressOut   = 32'h0;
        sramWriteDataOut = 32'h0;
        case (r_state)
            S_FILL_LO: begin
                sramRdEnOut    = 1'b1;
                sramAddressOut = w_blk;
            end
            S_FILL_HI: begin
                sramRdEnOut    = 1'b1;
                sramAddressOut = w_blk + 32'd4;
            end
            S_WRITE: begin
                sramWrEnOut      = 1'b1;
                sramAddressOut   = addressIn;
                sramWriteDataOut = writeDataIn;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wr_done  <= 1'b0;
            r_fill_buf <= 32'h0;
            for (int s = 0; s < c_NUM_SETS; s++) begin
                r_valid[0][s] <= 1'b0;
                r_valid[1][s] <= 1'b0;
                r_lru[s]      <= 1'b0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_wr_done) begin
                        r_wr_done <= 1'b0;
                    end else if (wrEnIn) begin
                        r_state <= S_WRITE;
                    end else if (rdEnIn) begin
                        if (w_hit) begin
                            r_lru[w_index] <= ~w_hit_way;
                        end else begin
                            r_state <= S_FILL_LO;
                        end
                    end
                end
                S_FILL_LO: begin
                    if (sramReadyIn) begin
                        r_fill_buf <= sramReadDataIn;
                        r_state    <= S_FILL_HI;
                    end
                end
                S_FILL_HI: begin
                    if (sramReadyIn) begin
                        r_valid[w_victim][w_index] <= 1'b1;
                        r_lru[w_index]             <= ~w_victim;
                        r_state                    <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    if (sramReadyIn) begin
                        if (w_hit) begin
                            r_lru[w_index] <= ~w_hit_way;
                        end
                        r_wr_done <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits gate them.
    always_ff @(posedge clk) begin
        if (w_fill_done) begin
            r_tag[w_victim][w_index]   <= w_tag;
            r_data0[w_victim][w_index] <= r_fill_buf;
            r_data1[w_victim][w_index] <= sramReadDataIn;
        end else if (w_write_done && w_hit) begin
            if (w_offset) begin
                r_data1[w_hit_way][w_index] <= writeDataIn;
            end else begin
                r_data0[w_hit_way][w_index] <= writeDataIn;
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic        r_after_fill;
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    // The hit that answers a just-filled miss is not counted as a hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_after_fill <= 1'b0;
            r_hit_cnt    <= 16'h0;
            r_miss_cnt   <= 16'h0;
        end else begin
            if (w_fill_done) begin
                r_after_fill <= 1'b1;
            end else if (r_state == S_IDLE) begin
                r_after_fill <= 1'b0;
            end
            if (w_rd_hit && !r_after_fill && (r_hit_cnt != 16'hFFFF)) begin
                r_hit_cnt <= r_hit_cnt + 16'd1;
            end
            if (w_miss_start && (r_miss_cnt != 16'hFFFF)) begin
                r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end

    assign hitCountOut  = r_hit_cnt;
    assign missCountOut = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// Randomized scoreboard bench for cache_controller: a transparent-memory plus
// per-set MRU-list model predicts data, hit/miss latency and SRAM traffic.
module tb_cache_controller;

    localparam int BASE = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdEnIn, wrEnIn;
    logic [31:0] addressIn, writeDataIn;
    logic [31:0] readDataOut;
    logic        readyOut;
    logic        sramRdEnOut, sramWrEnOut;
    logic [31:0] sramAddressOut, sramWriteDataOut;
    logic [31:0] sramReadDataIn;
    logic        sramReadyIn;
`ifdef CACHE_STATS_EN
    logic [15:0] hitCountOut, missCountOut;
`endif

    cache_controller dut (
        .clk              (clk),
        .rst              (rst),
        .rdEnIn           (rdEnIn),
        .wrEnIn           (wrEnIn),
        .addressIn        (addressIn),
        .writeDataIn      (writeDataIn),
        .readDataOut      (readDataOut),
        .readyOut         (readyOut),
        .sramRdEnOut      (sramRdEnOut),
        .sramWrEnOut      (sramWrEnOut),
        .sramAddressOut   (sramAddressOut),
        .sramWriteDataOut (sramWriteDataOut),
        .sramReadDataIn   (sramReadDataIn),
        .sramReadyIn      (sramReadyIn)
`ifdef CACHE_STATS_EN
        ,
        .hitCountOut      (hitCountOut),
        .missCountOut     (missCountOut)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        bit          hit;
        logic [31:0] data;
        logic [31:0] addr;
        int          lat;
    } exp_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } sram_op_t;

    exp_t        exp_q[$];
    sram_op_t    sram_log[$];
    int          checks = 0;
    int          failures = 0;
    int          lat = 3;
    int          m0[64];
    int          m1[64];
    int          exp_hits = 0;
    int          exp_misses = 0;
    int          tag_tab[4] = '{0, 1, 2, 1023};
    int          idx_tab[4] = '{0, 1, 62, 63};
    logic [31:0] sram_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] sram_rd(input logic [31:0] a);
        if (sram_mem.exists(a)) return sram_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    // Each set is an MRU-ordered list of at most two tags (-1 = empty slot).
    function automatic bit model_touch(input bit is_wr, input int idx, input int tag);
        if (m0[idx] == tag) return 1'b1;
        if (m1[idx] == tag) begin
            m1[idx] = m0[idx];
            m0[idx] = tag;
            return 1'b1;
        end
        if (!is_wr) begin
            m1[idx] = m0[idx];
            m0[idx] = tag;
        end
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 64; s++) begin
            m0[s] = -1;
            m1[s] = -1;
        end
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // SRAM: L enable cycles per access, ready in the L-th; DUT outputs sampled at negedge.
    initial begin
        bit          s_en, s_wr;
        logic [31:0] s_addr, s_wd;
        int          cnt;
        cnt = 0;
        sramReadyIn    = 1'b0;
        sramReadDataIn = 32'h0;
        forever begin
            @(negedge clk);
            s_en   = sramRdEnOut || sramWrEnOut;
            s_wr   = sramWrEnOut;
            s_addr = sramAddressOut;
            s_wd   = sramWriteDataOut;
            @(posedge clk);
            if (rst || !s_en) begin
                cnt = 0;
                sramReadyIn <= 1'b0;
            end else if (sramReadyIn) begin
                cnt = 0;
                sramReadyIn <= 1'b0;
            end else if (cnt >= lat - 2) begin
                sramReadyIn <= 1'b1;
                if (s_wr) begin
                    sram_mem[s_addr] = s_wd;
                    sram_log.push_back('{1'b1, s_addr, s_wd});
                end else begin
                    sramReadDataIn <= sram_rd(s_addr);
                    sram_log.push_back('{1'b0, s_addr, 32'h0});
                end
            end else begin
                cnt++;
            end
        end
    end

    // Monitor: pops one expectation per completed request.
    initial begin
        int   wait_cyc;
        exp_t e;
        logic [31:0] blk;
        wait_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst && (rdEnIn || wrEnIn)) begin
                if (readyOut) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_completion actual=1 required=0");
                    end else begin
                        e = exp_q.pop_front();
                        check("latency", 32'(wait_cyc),
                              e.is_wr ? 32'(e.lat) : (e.hit ? 32'd0 : 32'(2 * e.lat + 1)));
                        if (!e.is_wr) check("read_data", readDataOut, e.data);
                        blk = {e.addr[31:3], 3'b000};
                        if (e.is_wr) begin
                            check("sram_op_count", 32'(sram_log.size()), 32'd1);
                            if (sram_log.size() == 1) begin
                                check("sram_wr_kind", 32'(sram_log[0].wr), 32'd1);
                                check("sram_wr_addr", sram_log[0].addr, e.addr);
                                check("sram_wr_data", sram_log[0].data, e.data);
                            end
                        end else if (e.hit) begin
                            check("sram_op_count", 32'(sram_log.size()), 32'd0);
                        end else begin
                            check("sram_op_count", 32'(sram_log.size()), 32'd2);
                            if (sram_log.size() == 2) begin
                                check("fill_lo_addr", sram_log[0].addr, blk);
                                check("fill_hi_addr", sram_log[1].addr, blk + 32'd4);
                                check("fill_kind", 32'({sram_log[0].wr, sram_log[1].wr}), 32'd0);
                            end
                        end
                        sram_log.delete();
                    end
                    wait_cyc = 0;
                end else begin
                    wait_cyc++;
                end
            end else begin
                wait_cyc = 0;
            end
        end
    end

    task automatic do_req(input bit rd, input bit wr, input int tag, input int idx,
                          input bit off, input logic [31:0] wdata, input int l);
        exp_t        e;
        logic [31:0] a;
        int          n;
        @(posedge clk);
        #1;
        a       = 32'(BASE + (tag * 128 + idx * 2 + int'(off)) * 4);
        lat     = l;
        e.is_wr = wr;
        e.hit   = model_touch(wr, idx, tag);
        e.addr  = a;
        e.lat   = l;
        e.data  = wr ? wdata : ref_rd(a);
        if (wr) ref_mem[a] = wdata;
        else if (e.hit) exp_hits++;
        else exp_misses++;
        exp_q.push_back(e);
        rdEnIn      = rd;
        wrEnIn      = wr;
        addressIn   = a;
        writeDataIn = wdata;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!readyOut && n < 200);
        if (!readyOut) begin
            failures++;
            $display("FAIL request_timeout actual=%0d required<200", n);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
        @(posedge clk);
        #1;
        rdEnIn = 1'b0;
        wrEnIn = 1'b0;
        @(negedge clk);
        check(wr ? "post_write_ready" : "idle_ready", 32'(readyOut), wr ? 32'd0 : 32'd1);
        check("idle_rdata", readDataOut, 32'h0);
    endtask

    initial begin
        int          n;
        logic [31:0] ra;
        rst = 1'b1;
        rdEnIn = 1'b0;
        wrEnIn = 1'b0;
        addressIn = 32'h0;
        writeDataIn = 32'h0;
        model_clear();
        sram_mem[32'h400] = 32'hAAAA0000;
        sram_mem[32'h404] = 32'hBBBB1111;
        ref_mem[32'h400]  = 32'hAAAA0000;
        ref_mem[32'h404]  = 32'hBBBB1111;
        repeat (2) @(negedge clk);
        check("reset_ready", 32'(readyOut), 32'd1);
        check("reset_rdata", readDataOut, 32'h0);
        check("reset_sram_en", 32'({sramRdEnOut, sramWrEnOut}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        do_req(1, 0, 0, 0, 0, 32'h0, 5);             // 0x400 miss
        do_req(1, 0, 0, 0, 1, 32'h0, 5);             // 0x404 hit
        do_req(0, 1, 0, 0, 0, 32'h12345678, 3);      // write hit
        do_req(1, 0, 0, 0, 0, 32'h0, 3);             // hit new data
        do_req(1, 0, 256, 0, 0, 32'h0, 2);           // 0x20400 miss
        do_req(1, 0, 256, 0, 0, 32'h0, 2);           // hit, now MRU
        do_req(1, 0, 512, 0, 0, 32'h0, 2);           // 0x40400 evicts 0x400
        do_req(1, 0, 0, 0, 0, 32'h0, 2);             // 0x400 misses again
        do_req(0, 1, 5, 63, 1, 32'hCAFEF00D, 4);     // write miss, no allocate
        do_req(1, 0, 5, 63, 1, 32'h0, 2);            // miss, fetches written data
        do_req(1, 1, 5, 63, 0, 32'h0BADBEEF, 2);     // rd+wr acts as write
        do_req(1, 0, 5, 63, 0, 32'h0, 2);            // top set hit
        do_req(1, 0, 5, 0, 0, 32'h0, 2);             // set 0 independent

        // Reset in the middle of the second fill word.
        @(posedge clk);
        #1;
        lat = 4;
        ra = 32'(BASE + (7 * 128 + 5 * 2 + 1) * 4);
        rdEnIn = 1'b1;
        addressIn = ra;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sramRdEnOut && sramAddressOut == {ra[31:3], 3'b100}) && n < 100);
        check("fill_hi_reached", 32'(sramRdEnOut), 32'd1);
        #2;
        rst = 1'b1;
        rdEnIn = 1'b0;
        #1;
        check("rst_sram_rd", 32'(sramRdEnOut), 32'd0);
        check("rst_ready", 32'(readyOut), 32'd1);
        check("rst_rdata", readDataOut, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        sram_log.delete();
        model_clear();
        do_req(1, 0, 7, 5, 1, 32'h0, 3);             // full two-word fill again
        do_req(1, 0, 0, 0, 0, 32'h0, 3);             // cache was invalidated

        for (int i = 0; i < 300; i++) begin
            bit w, r;
            w = ($urandom_range(0, 9) < 3);
            r = w ? ($urandom_range(0, 2) == 0) : 1'b1;
            do_req(r, w, tag_tab[$urandom_range(0, 3)], idx_tab[$urandom_range(0, 3)],
                   1'($urandom_range(0, 1)), $urandom, $urandom_range(2, 5));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef CACHE_STATS_EN
        check("hit_count", 32'(hitCountOut), 32'(exp_hits));
        check("miss_count", 32'(missCountOut), 32'(exp_misses));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- 2-way set-associative read cache placed between the MEM-stage memory request and the SRAM controller.
- Read hits are answered in the same cycle. Read misses fetch a two-word block from SRAM. Writes are write-through, no-write-allocate.
- readyOut feeds the pipeline freeze in place of the raw SRAM ready.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- SET_BITS, 6: index width; 2^SET_BITS sets, 64 by default.
- TAG_BITS, 10: stored tag width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdEnIn  in  1  load request from MEM stage.
- wrEnIn  in  1  store request from MEM stage.
- addressIn  in  32  byte address (ALU result).
- writeDataIn  in  32  store data.
- readDataOut  out  32  load data; valid when readyOut=1 and rdEnIn=1.
- readyOut  out  1  request complete / idle; low freezes pipeline.
- sramRdEnOut  out  1  SRAM word read request.
- sramWrEnOut  out  1  SRAM word write request.
- sramAddressOut  out  32  SRAM byte address.
- sramWriteDataOut  out  32  SRAM write data.
- sramReadDataIn  in  32  SRAM read data, valid on completion.
- sramReadyIn  in  1  SRAM ready.

Behaviour:
- Clocking: one clock domain; rst is asynchronous, active-high.
- Address split:
  - w = (addressIn - BASE_ADDR) >> 2.
  - offset = w[0]; index = w[SET_BITS:1]; tag = w[SET_BITS+TAG_BITS:SET_BITS+1].
- Storage per set and way: valid bit, tag, data0 (even word), data1 (odd word). One LRU bit per set, naming the least-recently-used way.
- Request rules:
  - Requester holds inputs stable until readyOut=1.
  - rdEnIn=wrEnIn=1 is treated as a write.
- SRAM handshake:
  - Request enable is held high until completion.
  - Completion is any cycle with the enable high and sramReadyIn=1.
  - The enable drops in the following cycle.
  - The SRAM side must hold sramReadyIn low from the first request cycle until done.
- FSM states: IDLE, FILL_LO, FILL_HI, WRITE.
- IDLE, no request: readyOut=1, readDataOut=0, SRAM enables 0.
- IDLE, read hit (valid and tag match in either way):
  - readyOut=1 combinationally; readDataOut = hit way's word[offset].
  - LRU[index] set to the other way at the clock edge.
  - Stay in IDLE.
- IDLE, read miss: readyOut=0; go to FILL_LO.
- FILL_LO:
  - sramRdEnOut=1, sramAddressOut = block base (offset forced to 0).
  - On completion, latch data0 into a buffer and go to FILL_HI.
- FILL_HI:
  - sramRdEnOut=1, address = base+4.
  - On completion, write the LRU way: valid=1, tag, data0 from buffer, data1 = sramReadDataIn. Flip LRU[index] and go to IDLE.
  - The request then hits in IDLE. Miss latency = SRAM latency ×2 + 1 cycle.
- IDLE, write: readyOut=0; go to WRITE.
- WRITE:
  - sramWrEnOut=1, sramAddressOut=addressIn, sramWriteDataOut=writeDataIn.
  - On completion, readyOut=1 in that same cycle.
  - If hit, update the hit way's word[offset] and set LRU to the other way. A miss allocates nothing.
  - Go to IDLE one cycle later with readyOut=0, so the same write is not re-issued. Return to normal IDLE decoding the cycle after that.
- readyOut is low in FILL_LO, FILL_HI and WRITE, except on WRITE completion.
- Reset, including mid-fill or mid-write:
  - State=IDLE; all valid bits=0; LRU=0; fill buffer=0.
  - SRAM enables drop immediately.
  - readyOut=1 and readDataOut=0 while no request is present.
- Boundaries:
  - Index wrap: the top set and set 0 are independent.
  - Replacement when both ways are valid: way = LRU[index].
  - When both ways are invalid, way 0 is filled first (LRU=0 after reset).

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - Adds outputs hitCountOut[15:0] and missCountOut[15:0].
  - Counters saturate at 0xFFFF and reset to 0.
  - hit increments once per read hit (in the IDLE hit cycle, rdEnIn=1, not WRITE).
  - miss increments on the IDLE->FILL_LO transition.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then read 0x400 with SRAM latency 5, SRAM word0=0xAAAA0000, word1=0xBBBB1111 -> two SRAM reads at 0x400 and 0x404; readyOut=1 with readDataOut=0xAAAA0000 on the cycle after the second completion.
- Read 0x404 immediately after -> hit: readyOut=1 same cycle, data 0xBBBB1111, no SRAM request.
- Write 0x400=0x12345678 (hit) -> one SRAM write at 0x400, readyOut pulses at completion. A subsequent read of 0x400 hits with 0x12345678.
- Read 0x400, 0x20400 and 0x40400 (same index 0, three tags) -> third fill evicts the LRU way (0x400's way if 0x20400 was used last); re-reading 0x400 misses.
- Assert rst during FILL_HI -> sramRdEnOut=0 immediately; readyOut=1. A re-issued read of the same address misses and performs the full two-word fill.
- CACHE_STATS_EN defined, sequence of 1 miss then 3 hits -> missCountOut=1, hitCountOut=3.
